tcdm_req_issuer: RTL and testbench

//  Core-side initiator for the banked TCDM interconnect; the requesting end of the bank adapter protocol.

---
 rtl/tcdm_req_issuer.sv | 121 ++++++++++++
 tb/tb_tcdm_req_issuer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_req_issuer.sv
// TCDM core-side request issuer: tags outgoing requests and returns
// out-of-order bank responses to the core in issue order through a ROB.
module tcdm_req_issuer #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumOutstanding = 8,
  parameter int unsigned TagWidth       = $clog2(NumOutstanding)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [3:0]             req_amo_i,
  input  logic                   req_write_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [DataWidth-1:0]   resp_rdata_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [AddrWidth-1:0]   out_addr_o,
  output logic [3:0]             out_amo_o,
  output logic                   out_write_o,
  output logic [DataWidth-1:0]   out_wdata_o,
  output logic [DataWidth/8-1:0] out_be_o,
  output logic [TagWidth-1:0]    out_tag_o,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DataWidth-1:0]   in_rdata_i,
  input  logic [TagWidth-1:0]    in_tag_i,
  output logic [TagWidth:0]      outstanding_o
);

  if (DataWidth != 32) begin : g_dw_check
    $error("tcdm_req_issuer: DataWidth must be 32");
  end
  if (NumOutstanding < 2 ||
      (NumOutstanding & (NumOutstanding - 1)) != 0) begin : g_no_check
    $error("tcdm_req_issuer: NumOutstanding must be a power of 2 >= 2");
  end

  localparam logic [TagWidth:0] MaxCnt = (TagWidth+1)'(NumOutstanding);

  logic [TagWidth-1:0]       head_q, tail_q;
  logic [TagWidth:0]         count_q, count_d;
  logic [NumOutstanding-1:0] alloc_q, alloc_d;
  logic [NumOutstanding-1:0] done_q, done_d;
  logic [DataWidth-1:0]      data_q [NumOutstanding];
  logic                      full, issue, pop;

  // Full uses the registered count; a same-cycle pop never frees a slot.
  assign full = (count_q == MaxCnt);

  assign out_valid_o = rst_ni & req_valid_i & ~full;
  assign req_ready_o = rst_ni & out_ready_i & ~full;
  assign issue       = req_valid_i & req_ready_o;

  assign out_addr_o  = req_addr_i;
  assign out_amo_o   = req_amo_i;
  assign out_write_o = req_write_i;
  assign out_wdata_o = req_wdata_i;
  assign out_be_o    = req_be_i;
  assign out_tag_o   = tail_q;

  assign in_ready_o    = 1'b1;
  assign resp_valid_o  = done_q[head_q];
  assign resp_rdata_o  = data_q[head_q];
  assign pop           = resp_valid_o & resp_ready_i;
  assign outstanding_o = count_q;

  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    count_d = count_q;
    if (issue) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
    end
    if (in_valid_i) begin
      done_d[in_tag_i] = 1'b1;
    end
    if (pop) begin
      alloc_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    unique case ({issue, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      done_q  <= done_d;
      count_q <= count_d;
      if (issue) tail_q <= tail_q + 1'b1;
      if (pop)   head_q <= head_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_valid_i) data_q[in_tag_i] <= in_rdata_i;
  end

`ifndef SYNTHESIS
  a_resp_tag_live : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    in_valid_i |-> (alloc_q[in_tag_i] && !done_q[in_tag_i]));
`endif

endmodule

// File: tb/tb_tcdm_req_issuer.sv
// Bench for tcdm_req_issuer: vector table for single transactions plus
// directed ordering, full/wrap, backpressure and reset sequences.
module tb_tcdm_req_issuer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [3:0]  req_amo_i = '0;
  logic        req_write_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_be_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_addr_o;
  logic [3:0]  out_amo_o;
  logic        out_write_o;
  logic [31:0] out_wdata_o;
  logic [3:0]  out_be_o;
  logic [2:0]  out_tag_o;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_rdata_i = '0;
  logic [2:0]  in_tag_i = '0;
  logic [3:0]  outstanding_o;

  tcdm_req_issuer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_amo_i(req_amo_i),
    .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
    .req_be_i(req_be_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_amo_o(out_amo_o),
    .out_write_o(out_write_o), .out_wdata_o(out_wdata_o),
    .out_be_o(out_be_o), .out_tag_o(out_tag_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rdata_i(in_rdata_i), .in_tag_i(in_tag_i),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  amo;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic [2:0]  exp_tag;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] exp_q [$];
  logic [31:0] rsp_data [8];
  logic [2:0]  m_tail = '0;
  int          m_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic accept(input logic [31:0] rd);
    exp_q.push_back(rd);
    rsp_data[m_tail] = rd;
    m_tail = m_tail + 3'd1;
    m_cnt++;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [3:0] amo,
                         input logic w, input logic [31:0] wd,
                         input logic [3:0] be);
    req_addr_i = a; req_amo_i = amo; req_write_i = w;
    req_wdata_i = wd; req_be_i = be; req_valid_i = 1'b1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] rd);
    set_req(a, 4'h0, 1'b0, 32'h0, 4'hF);
    tick();
    accept(rd);
    req_valid_i = 1'b0;
  endtask

  task automatic drive_in(input logic [2:0] tag);
    in_valid_i = 1'b1;
    in_tag_i   = tag;
    in_rdata_i = rsp_data[tag];
  endtask

  task automatic reply(input logic [2:0] tag);
    drive_in(tag);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [31:0] e;
    chk({name, "_valid"}, {31'd0, resp_valid_o}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk({name, "_rdata"}, resp_rdata_o, e);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    m_cnt--;
  endtask

  initial begin
    logic [2:0]  b;
    logic [31:0] held;
    vecs[0] = '{32'h100, 4'h0, 1'b0, 32'h0,        4'hF,
                32'hDEADBEEF, 3'd0};
    vecs[1] = '{32'h200, 4'h0, 1'b1, 32'h12345678, 4'h3,
                32'h0, 3'd1};
    vecs[2] = '{32'h40,  4'h2, 1'b0, 32'h5,        4'hF,
                32'h7, 3'd2};
    vecs[3] = '{32'h80,  4'hA, 1'b0, 32'h0,        4'hF,
                32'h11, 3'd3};
    vecs[4] = '{32'h80,  4'hB, 1'b1, 32'h99,       4'hF,
                32'h0, 3'd4};

    // reset state, with a request already pending
    req_valid_i = 1'b1;
    #12;
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_out_tag", {29'd0, out_tag_o}, 32'd0);
    chk("rst_outstanding", {28'd0, outstanding_o}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    req_valid_i = 1'b0;
    rst_ni = 1'b1;
    tick();

    // table: issue, check pass-through, reply, next-cycle response
    for (int i = 0; i < 5; i++) begin
      set_req(vecs[i].addr, vecs[i].amo, vecs[i].wr,
              vecs[i].wdata, vecs[i].be);
      #1;
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid_o}, 32'd1);
      chk($sformatf("v%0d_req_ready", i), {31'd0, req_ready_o}, 32'd1);
      chk($sformatf("v%0d_addr", i), out_addr_o, vecs[i].addr);
      chk($sformatf("v%0d_amo", i), {28'd0, out_amo_o}, {28'd0, vecs[i].amo});
      chk($sformatf("v%0d_write", i), {31'd0, out_write_o},
          {31'd0, vecs[i].wr});
      chk($sformatf("v%0d_wdata", i), out_wdata_o, vecs[i].wdata);
      chk($sformatf("v%0d_be", i), {28'd0, out_be_o}, {28'd0, vecs[i].be});
      chk($sformatf("v%0d_tag", i), {29'd0, out_tag_o},
          {29'd0, vecs[i].exp_tag});
      tick();
      accept(vecs[i].rdata);
      req_valid_i = 1'b0;
      chk($sformatf("v%0d_outstanding", i), {28'd0, outstanding_o}, m_cnt);
      reply(vecs[i].exp_tag);
      pop_check($sformatf("v%0d_resp", i));
    end
    chk("tbl_outstanding", {28'd0, outstanding_o}, m_cnt);

    // out-of-order replies released in issue order
    b = m_tail;
    issue(32'h300, 32'hB0000000);
    issue(32'h304, 32'hB0000001);
    issue(32'h308, 32'hB0000002);
    resp_ready_i = 1'b1;
    reply(b + 3'd2);
    chk("ooo_wait_valid", {31'd0, resp_valid_o}, 32'd0);
    drive_in(b);
    tick();
    drive_in(b + 3'd1);
    chk("ooo_r0_valid", {31'd0, resp_valid_o}, 32'd1);
    chk("ooo_r0_rdata", resp_rdata_o, exp_q.pop_front());
    tick();
    in_valid_i = 1'b0;
    chk("ooo_r1_valid", {31'd0, resp_valid_o}, 32'd1);
    chk("ooo_r1_rdata", resp_rdata_o, exp_q.pop_front());
    tick();
    chk("ooo_r2_valid", {31'd0, resp_valid_o}, 32'd1);
    chk("ooo_r2_rdata", resp_rdata_o, exp_q.pop_front());
    tick();
    resp_ready_i = 1'b0;
    m_cnt -= 3;
    chk("ooo_drained", {31'd0, resp_valid_o}, 32'd0);
    chk("ooo_outstanding", {28'd0, outstanding_o}, m_cnt);

    // fill the ROB, pop one, tag wraps
    b = m_tail;
    for (int i = 0; i < 8; i++) issue(32'h1000 + i * 4, 32'hC0000000 + i);
    req_valid_i = 1'b1;
    #1;
    chk("full_outstanding", {28'd0, outstanding_o}, 32'd8);
    chk("full_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("full_out_valid", {31'd0, out_valid_o}, 32'd0);
    reply(b);
    req_valid_i = 1'b1;
    resp_ready_i = 1'b1;
    #1;
    chk("full_no_bypass", {31'd0, req_ready_o}, 32'd0);
    chk("full_pop_rdata", resp_rdata_o, exp_q.pop_front());
    tick();
    resp_ready_i = 1'b0;
    m_cnt--;
    chk("full_ready_after_pop", {31'd0, req_ready_o}, 32'd1);
    chk("full_wrap_tag", {29'd0, out_tag_o}, {29'd0, m_tail});
    issue(32'h2000, 32'hC0000008);
    for (int i = 1; i <= 8; i++) begin
      reply(b + 3'(i));
      pop_check($sformatf("full_drain%0d", i));
    end
    chk("full_empty", {28'd0, outstanding_o}, 32'd0);

    // network backpressure, then core backpressure on a response
    b = m_tail;
    out_ready_i = 1'b0;
    set_req(32'h500, 4'h0, 1'b0, 32'h0, 4'hF);
    #1;
    chk("bp_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
    tick();
    chk("bp_tag_stays", {29'd0, out_tag_o}, {29'd0, b});
    chk("bp_outstanding", {28'd0, outstanding_o}, 32'd0);
    req_valid_i = 1'b0;
    out_ready_i = 1'b1;
    issue(32'h500, 32'hCAFEF00D);
    reply(b);
    held = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_valid", i), {31'd0, resp_valid_o}, 32'd1);
      chk($sformatf("hold%0d_rdata", i), resp_rdata_o, held);
      tick();
    end
    pop_check("hold_release");

    // reset with three in flight
    issue(32'h600, 32'hD0000000);
    issue(32'h604, 32'hD0000001);
    issue(32'h608, 32'hD0000002);
    reply(m_tail - 3'd3);
    chk("prerst_resp_valid", {31'd0, resp_valid_o}, 32'd1);
    req_valid_i = 1'b1;
    #3;
    rst_ni = 1'b0;
    #1;
    chk("midrst_req_ready", {31'd0, req_ready_o}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("midrst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("midrst_outstanding", {28'd0, outstanding_o}, 32'd0);
    chk("midrst_out_tag", {29'd0, out_tag_o}, 32'd0);
    req_valid_i = 1'b0;
    exp_q.delete();
    m_tail = '0;
    m_cnt = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("postrst_tag", {29'd0, out_tag_o}, 32'd0);
    chk("postrst_outstanding", {28'd0, outstanding_o}, 32'd0);
    issue(32'h700, 32'hE0000000);
    reply(3'd0);
    pop_check("postrst_resp");
    chk("final_outstanding", {28'd0, outstanding_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
